branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences control-flow redirects for the RV32I pipeline. Evaluates the EX-stage branch condition
//  (static predict-not-taken) and computes the target. On a taken branch it performs a valid/ready
//  redirect handshake with fetch, then flushes and holds the younger stages for a fixed window.
//  Also flags misaligned targets to the trap unit and keeps branch/taken performance counters.
// PARAMETERS
//  XLEN          32  datapath width
//  FLUSH_CYCLES  2   cycles flush/hold stay high after redirect accepted (>=1)
//  CNT_W         32  width of performance counters
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous active-high reset
//  ex_valid        in   1      EX holds a valid instruction this cycle
//  ex_branch_cond  in   3      000 NOB,001 BEQ,010 BNE,011 BLT,100 BGE,101 BLTU,110 BGEU,111 JMP
//  ex_is_jalr      in   1      JMP target is register-relative (JALR)
//  ex_src1         in   XLEN   rs1 value
//  ex_src2         in   XLEN   rs2 value
//  ex_pc           in   XLEN   PC of the EX instruction
//  ex_imm          in   XLEN   sign-extended offset
//  redirect_valid  out  1      redirect request to fetch
//  redirect_ready  in   1      fetch accepts redirect_pc
//  redirect_pc     out  XLEN   new fetch address
//  flush           out  1      kill IF/ID contents
//  hold            out  1      stall IF/ID/EX advance; EX inputs ignored while high
//  misalign_trap   out  1      one-cycle pulse: taken target misaligned
//  misalign_addr   out  XLEN   offending target, valid with misalign_trap
//  branch_count    out  CNT_W  count of accepted non-NOB ex_valid cycles
//  taken_count     out  CNT_W  count of redirects issued
// BEHAVIOUR
//  Reset: state IDLE; all 1-bit outputs 0; redirect_pc, misalign_addr, both counters 0.
//    rst in any state, incl. mid-handshake: next cycle is IDLE with reset values, redirect dropped.
//  Evaluation (combinational, EX inputs): BEQ/BNE on equality; BLT/BGE signed; BLTU/BGEU unsigned.
//    JMP always taken; NOB never taken.
//  Target: JMP & ex_is_jalr -> (src1+imm) & ~1; else pc+imm; XLEN-bit wrap-around add.
//  FSM IDLE/REDIRECT/FLUSH. An EX instruction is accepted only when state==IDLE & ex_valid.
//  IDLE, accepted at cycle N:
//    - cond!=NOB: branch_count+1 at N+1.
//    - taken & target[1:0]!=0: misalign_trap=1 and misalign_addr=target in cycle N+1 only.
//      Stay IDLE; no redirect, no flush.
//    - taken & aligned: redirect_pc<=target, taken_count+1, enter REDIRECT at N+1.
//    - not taken: no other effect.
//  REDIRECT: redirect_valid=flush=hold=1; redirect_pc stable until accepted.
//    redirect_valid stays high until redirect_ready; it is never withdrawn.
//    Transfer cycle (valid&ready) -> FLUSH, down-counter loaded with FLUSH_CYCLES-1.
//  FLUSH: flush=hold=1, redirect_valid=0; the state lasts exactly FLUSH_CYCLES cycles, then IDLE.
//  hold=flush=(state!=IDLE): registered outputs, no combinational path from EX inputs.
//  ex_valid in REDIRECT/FLUSH is ignored: no count, trap or redirect.
//  Counters wrap modulo 2^CNT_W.
// TESTING
//  1. BEQ src1=src2=5, pc=0x100, imm=0x20, ready=1 -> N+1: redirect_valid, pc=0x120.
//     flush high 3 cycles (N+1..N+3); taken_count=1, branch_count=1.
//  2. src1=0xFFFFFFFF, src2=1: BLT -> taken, redirect; BLTU -> not taken.
//     BLTU: no flush, branch_count +1.
//  3. JMP jalr src1=0x1003, imm=4 -> target 0x1006, misalign_trap 1 cycle, misalign_addr=0x1006.
//     No redirect; taken_count unchanged.
//  4. Taken branch, redirect_ready low 5 cycles -> redirect_valid/hold/redirect_pc stable 5 cycles.
//     ex_valid pulses meanwhile ignored (counters unchanged); flush spans 5+1+2 cycles.
//  5. rst asserted during FLUSH -> next cycle IDLE; all outputs 0; counters 0.
//     A new BEQ is then handled normally.
//  6. ex_valid with NOB, and cond=BNE with ex_valid=0 -> no output change, counters unchanged.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the branch controller (master) and fetch (slave).
interface branch_redirect_ctrl_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX-stage branches (predict-not-taken), issues the fetch redirect and
// holds/flushes the younger stages for a fixed window afterwards.
//
//   state      | meaning
//   S_IDLE     | accepting EX instructions
//   S_REDIRECT | redirect offered to fetch, waiting for ready
//   S_FLUSH    | redirect taken, flush/hold for FLUSH_CYCLES cycles
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [2:0]             ex_branch_cond,
    input  logic                   ex_is_jalr,
    input  logic [XLEN-1:0]        ex_src1,
    input  logic [XLEN-1:0]        ex_src2,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [XLEN-1:0]        ex_imm,
    branch_redirect_ctrl_if.master redir,
    output logic                   flush,
    output logic                   hold,
    output logic                   misalign_trap,
    output logic [XLEN-1:0]        misalign_addr,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       taken_count
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] C_NOB  = 3'b000;
    localparam logic [2:0] C_BEQ  = 3'b001;
    localparam logic [2:0] C_BNE  = 3'b010;
    localparam logic [2:0] C_BLT  = 3'b011;
    localparam logic [2:0] C_BGE  = 3'b100;
    localparam logic [2:0] C_BLTU = 3'b101;
    localparam logic [2:0] C_BGEU = 3'b110;
    localparam logic [2:0] C_JMP  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [XLEN-1:0]   rpc_q, rpc_n;
    logic              trap_q, trap_n;
    logic [XLEN-1:0]   maddr_q, maddr_n;
    logic [CNT_W-1:0]  bc_q, bc_n;
    logic [CNT_W-1:0]  tc_q, tc_n;
    logic              taken;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   jalr_sum;

    always_comb begin
        taken = 1'b0;
        case (ex_branch_cond)
            C_NOB:   taken = 1'b0;
            C_BEQ:   taken = (ex_src1 == ex_src2);
            C_BNE:   taken = (ex_src1 != ex_src2);
            C_BLT:   taken = ($signed(ex_src1) <  $signed(ex_src2));
            C_BGE:   taken = ($signed(ex_src1) >= $signed(ex_src2));
            C_BLTU:  taken = (ex_src1 <  ex_src2);
            C_BGEU:  taken = (ex_src1 >= ex_src2);
            C_JMP:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the sum; bit 1 can still be set and must trap
    assign jalr_sum = ex_src1 + ex_imm;
    assign target   = (ex_branch_cond == C_JMP && ex_is_jalr)
                    ? {jalr_sum[XLEN-1:1], 1'b0}
                    : ex_pc + ex_imm;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rpc_n   = rpc_q;
        trap_n  = 1'b0;
        maddr_n = maddr_q;
        bc_n    = bc_q;
        tc_n    = tc_q;
        case (state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (ex_branch_cond != C_NOB) bc_n = bc_q + CNT_W'(1);
                    if (taken) begin
                        if (target[1:0] != 2'b00) begin
                            trap_n  = 1'b1;
                            maddr_n = target;
                        end else begin
                            rpc_n   = target;
                            tc_n    = tc_q + CNT_W'(1);
                            state_n = S_REDIRECT;
                        end
                    end
                end
            end
            S_REDIRECT: begin
                if (redir.redirect_ready) begin
                    state_n = S_FLUSH;
                    cnt_n   = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (cnt == '0) state_n = S_IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rpc_q   <= '0;
            trap_q  <= 1'b0;
            maddr_q <= '0;
            bc_q    <= '0;
            tc_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rpc_q   <= rpc_n;
            trap_q  <= trap_n;
            maddr_q <= maddr_n;
            bc_q    <= bc_n;
            tc_q    <= tc_n;
        end
    end

    assign redir.redirect_valid = (state == S_REDIRECT);
    assign redir.redirect_pc    = rpc_q;
    assign flush                = (state != S_IDLE);
    assign hold                 = (state != S_IDLE);
    assign misalign_trap        = trap_q;
    assign misalign_addr        = maddr_q;
    assign branch_count         = bc_q;
    assign taken_count          = tc_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized and directed stimulus for branch_redirect_ctrl, checked every cycle
// against a transaction-level reference model.
module tb_branch_redirect_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_branch_cond;
    logic        ex_is_jalr;
    logic [31:0] ex_src1, ex_src2, ex_pc, ex_imm;
    logic        flush, hold, misalign_trap;
    logic [31:0] misalign_addr, branch_count, taken_count;

    branch_redirect_ctrl_if #(.XLEN(32)) redir ();

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch_cond (ex_branch_cond),
        .ex_is_jalr     (ex_is_jalr),
        .ex_src1        (ex_src1),
        .ex_src2        (ex_src2),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .redir          (redir.master),
        .flush          (flush),
        .hold           (hold),
        .misalign_trap  (misalign_trap),
        .misalign_addr  (misalign_addr),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: a pending redirect plus a count of remaining flush cycles
    bit          m_pend;
    int          m_flush_left;
    bit [31:0]   m_rpc, m_maddr, m_bc, m_tc;
    bit          m_trap;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit ref_taken(bit [2:0] c, bit [31:0] a, bit [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (c)
            3'd1: return sa == sb;
            3'd2: return sa != sb;
            3'd3: return sa < sb;
            3'd4: return sa >= sb;
            3'd5: return ua < ub;
            3'd6: return ua >= ub;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] ref_target(bit [2:0] c, bit j, bit [31:0] a, bit [31:0] p, bit [31:0] imm);
        if (c == 3'd7 && j) return (a + imm) & 32'hFFFF_FFFE;
        return p + imm;
    endfunction

    task automatic model_update();
        bit [31:0] t;
        if (rst) begin
            m_pend = 0; m_flush_left = 0; m_rpc = 0; m_maddr = 0;
            m_bc = 0; m_tc = 0; m_trap = 0;
            return;
        end
        m_trap = 0;
        if (m_pend) begin
            if (redir.redirect_ready) begin
                m_pend = 0;
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (ex_valid) begin
            if (ex_branch_cond != 3'd0) m_bc++;
            if (ref_taken(ex_branch_cond, ex_src1, ex_src2)) begin
                t = ref_target(ex_branch_cond, ex_is_jalr, ex_src1, ex_pc, ex_imm);
                if (t % 4 != 0) begin
                    m_trap  = 1;
                    m_maddr = t;
                end else begin
                    m_rpc  = t;
                    m_tc++;
                    m_pend = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit busy = m_pend || (m_flush_left > 0);
        check_val("redirect_valid", redir.redirect_valid, m_pend);
        check_val("redirect_pc", redir.redirect_pc, m_rpc);
        check_val("flush", flush, busy);
        check_val("hold", hold, busy);
        check_val("misalign_trap", misalign_trap, m_trap);
        check_val("misalign_addr", misalign_addr, m_maddr);
        check_val("branch_count", branch_count, m_bc);
        check_val("taken_count", taken_count, m_tc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic set_ex(input bit v, input bit [2:0] c, input bit j, input bit [31:0] a,
                          input bit [31:0] b, input bit [31:0] p, input bit [31:0] imm);
        ex_valid = v; ex_branch_cond = c; ex_is_jalr = j;
        ex_src1 = a; ex_src2 = b; ex_pc = p; ex_imm = imm;
    endtask

    task automatic idle_steps(input int n);
        set_ex(0, 3'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        redir.redirect_ready = 1'b1;
        set_ex(0, 3'd0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        idle_steps(2);

        // BEQ taken, fetch ready at once
        set_ex(1, 3'd1, 0, 5, 5, 32'h100, 32'h20);
        step();
        check_val("t1_redirect_pc", redir.redirect_pc, 32'h120);
        idle_steps(4);

        // BLT signed taken, BLTU unsigned not taken
        set_ex(1, 3'd3, 0, 32'hFFFF_FFFF, 1, 32'h200, 32'h40);
        step();
        idle_steps(4);
        set_ex(1, 3'd5, 0, 32'hFFFF_FFFF, 1, 32'h200, 32'h40);
        step();
        check_val("t2_bltu_flush", flush, 1'b0);
        idle_steps(2);

        // JALR to a misaligned target traps without redirect
        set_ex(1, 3'd7, 1, 32'h1003, 0, 32'h300, 4);
        step();
        check_val("t3_misalign_addr", misalign_addr, 32'h1006);
        idle_steps(2);

        // fetch stalls the redirect, EX pulses in the meantime are ignored
        redir.redirect_ready = 1'b0;
        set_ex(1, 3'd2, 0, 1, 2, 32'h400, 32'h80);
        step();
        for (int i = 0; i < 5; i++) begin
            set_ex(i % 2 == 0, 3'd7, 0, 0, 0, 32'h500, 32'h10);
            step();
        end
        redir.redirect_ready = 1'b1;
        idle_steps(4);

        // reset in the middle of the flush window, then a normal BEQ
        set_ex(1, 3'd1, 0, 7, 7, 32'h600, 32'h8);
        step();
        set_ex(0, 3'd0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ex(1, 3'd1, 0, 9, 9, 32'h700, 32'hC);
        step();
        idle_steps(4);

        // NOB accepted and BNE without ex_valid change nothing
        set_ex(1, 3'd0, 0, 1, 2, 32'h800, 32'h10);
        step();
        set_ex(0, 3'd2, 0, 1, 2, 32'h800, 32'h10);
        step();
        idle_steps(1);

        for (int i = 0; i < 3000; i++) begin
            bit [31:0] vals [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
            bit [31:0] a = ($urandom % 2) ? vals[$urandom % 4] : $urandom;
            bit [31:0] b = ($urandom % 2) ? vals[$urandom % 4] : $urandom;
            bit [31:0] imm = ($urandom % 4 == 0) ? $urandom : ($urandom_range(0, 255) << 2);
            rst = ($urandom % 200 == 0);
            redir.redirect_ready = ($urandom % 3 != 0);
            set_ex($urandom % 4 != 0, 3'($urandom % 8), 1'($urandom % 2), a,
                   ($urandom % 3 == 0) ? a : b, $urandom & 32'hFFFF_FFFC, imm);
            step();
        end
        rst = 1'b0;
        idle_steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
